// File: rtl/up_pkg.sv
// Shared opcode constants and controller state encoding for the up_core
// accumulator sequencer.
package up_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_LD   = 8'h02;
  localparam logic [7:0] OP_ST   = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h04;
  localparam logic [7:0] OP_SUB  = 8'h05;
  localparam logic [7:0] OP_ADDR = 8'h06;
  localparam logic [7:0] OP_AND  = 8'h07;
  localparam logic [7:0] OP_OR   = 8'h08;
  localparam logic [7:0] OP_XOR  = 8'h09;
  localparam logic [7:0] OP_JMP  = 8'h10;
  localparam logic [7:0] OP_JZ   = 8'h11;
  localparam logic [7:0] OP_JNZ  = 8'h12;
  localparam logic [7:0] OP_CALL = 8'h13;
  localparam logic [7:0] OP_RET  = 8'h14;
  localparam logic [7:0] OP_HALT = 8'hFF;

endpackage

// File: rtl/up_stack.sv
// LIFO return-address stack; push and pop are ignored when full or empty
// respectively, so the caller can treat those as fault conditions.
module up_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      sp_q;
  logic [AW:0]      top_idx;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full     = (sp_q == (AW+1)'(DEPTH));
  assign empty    = (sp_q == '0);
  assign top_idx  = sp_q - (AW+1)'(1);
  assign data_out = mem[top_idx[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + (AW+1)'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_q - (AW+1)'(1);
    end
  end

  // Entries are not reset: only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (push && !full) mem[sp_q[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/up_core.sv
// Two-cycle accumulator micro-sequencer with register file, ALU and return stack.
//   state | meaning
//   FETCH | present pc on imem_addr
//   EXEC  | decode imem_data, update acc/flags/pc
//   HALT  | stopped by HALT, everything frozen until reset
//   ERROR | stack fault or illegal opcode, frozen until reset
module up_core
  import up_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int PC_W        = 8,
  parameter int REG_NUM     = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [8+DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0]   out,
  output logic                zero,
  output logic                carry,
  output logic                halted,
  output logic                error
);

  localparam int RA_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d, halted_q, halted_d, error_q, error_d;
  logic [7:0]        opcode;
  logic [DATA_W-1:0] imm, reg_rd;
  logic [DATA_W:0]   sum_imm, diff_imm, sum_reg;
  logic              reg_we, push, pop, stk_full, stk_empty;
  logic [PC_W-1:0]   stk_top;
  logic [DATA_W-1:0] regs [REG_NUM];

  assign opcode    = imem_data[8+DATA_W-1:DATA_W];
  assign imm       = imem_data[DATA_W-1:0];
  assign reg_rd    = regs[imm[RA_W-1:0]];
  assign sum_imm   = {1'b0, acc_q} + {1'b0, imm};
  assign diff_imm  = {1'b0, acc_q} - {1'b0, imm};
  assign sum_reg   = {1'b0, acc_q} + {1'b0, reg_rd};
  assign pc_inc    = pc_q + PC_W'(1);

  assign imem_addr = pc_q;
  assign out       = acc_q;
  assign zero      = (acc_q == '0);
  assign carry     = carry_q;
  assign halted    = halted_q;
  assign error     = error_q;

  up_stack #(.WIDTH(PC_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk      (clk_in),
    .rst      (rst_in),
    .push     (push),
    .pop      (pop),
    .data_in  (pc_inc),
    .full     (stk_full),
    .empty    (stk_empty),
    .data_out (stk_top)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    halted_d = halted_q;
    error_d  = error_q;
    reg_we   = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        case (opcode)
          OP_NOP:  ;
          OP_LDI:  acc_d = imm;
          OP_LD:   acc_d = reg_rd;
          OP_ST:   reg_we = 1'b1;
          OP_ADD:  {carry_d, acc_d} = sum_imm;
          OP_SUB:  {carry_d, acc_d} = diff_imm;
          OP_ADDR: {carry_d, acc_d} = sum_reg;
          OP_AND:  acc_d = acc_q & imm;
          OP_OR:   acc_d = acc_q | imm;
          OP_XOR:  acc_d = acc_q ^ imm;
          OP_JMP:  pc_d = imm[PC_W-1:0];
          OP_JZ:   if (zero) pc_d = imm[PC_W-1:0];
          OP_JNZ:  if (!zero) pc_d = imm[PC_W-1:0];
          OP_CALL: begin
            if (stk_full) begin
              pc_d    = pc_q;
              error_d = 1'b1;
              state_d = ST_ERROR;
            end else begin
              push = 1'b1;
              pc_d = imm[PC_W-1:0];
            end
          end
          OP_RET: begin
            if (stk_empty) begin
              pc_d    = pc_q;
              error_d = 1'b1;
              state_d = ST_ERROR;
            end else begin
              pop  = 1'b1;
              pc_d = stk_top;
            end
          end
          OP_HALT: begin
            pc_d     = pc_q;
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: begin
            pc_d    = pc_q;
            error_d = 1'b1;
            state_d = ST_ERROR;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      halted_q <= halted_d;
      error_q  <= error_d;
    end
  end

  // Register file survives reset; writes only happen from EXEC.
  always_ff @(posedge clk_in) begin
    if (reg_we) regs[imm[RA_W-1:0]] <= acc_q;
  end

endmodule

// File: tb/tb_up_core.sv
// Directed bench for up_core: small programs in a one-cycle-latency ROM model.
module tb_up_core;
  import up_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [7:0]  imem_addr;
  logic [23:0] imem_data;
  logic [15:0] out;
  logic        zero, carry, halted, error;

  logic [23:0] rom [256];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) imem_data <= rom[imem_addr];

  up_core dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .out       (out),
    .zero      (zero),
    .carry     (carry),
    .halted    (halted),
    .error     (error)
  );

  task automatic hold_reset();
    rst_in = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = {OP_NOP, 16'h0000};
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  task automatic release_reset();
    rst_in = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    hold_reset();
    n_vec++; if (out !== 16'h0000) begin n_err++; $display("FAIL reset_out got %h want 0000", out); end
    n_vec++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset_zero got %b want 1", zero); end
    n_vec++; if ({carry, halted, error} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {carry, halted, error}); end
    n_vec++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr got %h want 00", imem_addr); end
  endtask

  task automatic test_arith();
    hold_reset();
    rom[0] = {OP_LDI,  16'd5};
    rom[1] = {OP_ADD,  16'd3};
    rom[2] = {OP_ST,   16'd2};
    rom[3] = {OP_LDI,  16'd0};
    rom[4] = {OP_ADDR, 16'd2};
    release_reset();
    run(4);
    n_vec++; if (out !== 16'd8) begin n_err++; $display("FAIL arith_add got %h want 0008", out); end
    run(6);
    n_vec++; if (out !== 16'd8) begin n_err++; $display("FAIL arith_addr_out got %h want 0008", out); end
    n_vec++; if ({zero, carry} !== 2'b00) begin n_err++; $display("FAIL arith_addr_flags got %b want 00", {zero, carry}); end
    n_vec++; if (imem_addr !== 8'h05) begin n_err++; $display("FAIL arith_pc got %h want 05", imem_addr); end
  endtask

  task automatic test_regfile_persist();
    hold_reset();
    rom[0] = {OP_LD, 16'h0012};
    release_reset();
    run(2);
    n_vec++; if (out !== 16'd8) begin n_err++; $display("FAIL regfile_persist got %h want 0008", out); end
  endtask

  task automatic test_carry_logic();
    hold_reset();
    rom[0] = {OP_LDI, 16'hFFFF};
    rom[1] = {OP_ADD, 16'h0001};
    rom[2] = {OP_SUB, 16'h0001};
    rom[3] = {OP_AND, 16'h00FF};
    rom[4] = {OP_OR,  16'h0F00};
    rom[5] = {OP_XOR, 16'h0FF0};
    rom[6] = {OP_SUB, 16'h0005};
    release_reset();
    run(4);
    n_vec++; if ({out, zero, carry} !== {16'h0000, 2'b11}) begin n_err++; $display("FAIL add_wrap got %h z%b c%b want 0000 z1 c1", out, zero, carry); end
    run(2);
    n_vec++; if ({out, zero, carry} !== {16'hFFFF, 2'b01}) begin n_err++; $display("FAIL sub_borrow got %h z%b c%b want ffff z0 c1", out, zero, carry); end
    run(2);
    n_vec++; if ({out, carry} !== {16'h00FF, 1'b1}) begin n_err++; $display("FAIL and_keeps_carry got %h c%b want 00ff c1", out, carry); end
    run(2);
    n_vec++; if (out !== 16'h0FFF) begin n_err++; $display("FAIL or got %h want 0fff", out); end
    run(2);
    n_vec++; if (out !== 16'h000F) begin n_err++; $display("FAIL xor got %h want 000f", out); end
    run(2);
    n_vec++; if ({out, carry} !== {16'h000A, 1'b0}) begin n_err++; $display("FAIL sub_no_borrow got %h c%b want 000a c0", out, carry); end
  endtask

  task automatic test_jumps();
    hold_reset();
    rom[0] = {OP_LDI, 16'h0000};
    rom[1] = {OP_JZ,  16'h0020};
    release_reset();
    run(4);
    n_vec++; if (imem_addr !== 8'h20) begin n_err++; $display("FAIL jz_taken got %h want 20", imem_addr); end
    hold_reset();
    rom[0] = {OP_LDI, 16'h0001};
    rom[1] = {OP_JZ,  16'h0020};
    release_reset();
    run(4);
    n_vec++; if (imem_addr !== 8'h02) begin n_err++; $display("FAIL jz_not_taken got %h want 02", imem_addr); end
    hold_reset();
    rom[0]     = {OP_LDI, 16'h0001};
    rom[1]     = {OP_JNZ, 16'h0130};
    rom[8'h30] = {OP_JMP, 16'h0005};
    release_reset();
    run(4);
    n_vec++; if (imem_addr !== 8'h30) begin n_err++; $display("FAIL jnz_taken got %h want 30", imem_addr); end
    run(2);
    n_vec++; if (imem_addr !== 8'h05) begin n_err++; $display("FAIL jmp got %h want 05", imem_addr); end
  endtask

  task automatic test_call_ret();
    hold_reset();
    rom[3]     = {OP_CALL, 16'h0040};
    rom[8'h40] = {OP_RET,  16'h0000};
    release_reset();
    run(8);
    n_vec++; if (imem_addr !== 8'h40) begin n_err++; $display("FAIL call_target got %h want 40", imem_addr); end
    run(2);
    n_vec++; if (imem_addr !== 8'h04) begin n_err++; $display("FAIL ret_addr got %h want 04", imem_addr); end
    n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL call_ret_error got %b want 0", error); end
  endtask

  task automatic test_stack_faults();
    hold_reset();
    for (int i = 0; i < 5; i++) rom[i] = {OP_CALL, 16'(i + 1)};
    release_reset();
    run(8);
    n_vec++; if ({imem_addr, error} !== {8'h04, 1'b0}) begin n_err++; $display("FAIL four_calls got %h e%b want 04 e0", imem_addr, error); end
    run(2);
    n_vec++; if (error !== 1'b1) begin n_err++; $display("FAIL overflow_error got %b want 1", error); end
    n_vec++; if (dut.state_q !== ST_ERROR) begin n_err++; $display("FAIL overflow_state got %0d want %0d", dut.state_q, ST_ERROR); end
    run(6);
    n_vec++; if (imem_addr !== 8'h04) begin n_err++; $display("FAIL overflow_pc_frozen got %h want 04", imem_addr); end
    hold_reset();
    rom[0] = {OP_RET, 16'h0000};
    release_reset();
    run(2);
    n_vec++; if ({error, imem_addr} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL underflow got e%b %h want e1 00", error, imem_addr); end
  endtask

  task automatic test_halt();
    int bad;
    hold_reset();
    rom[0] = {OP_LDI,  16'h0042};
    rom[7] = {OP_HALT, 16'h0000};
    rom[8] = {OP_LDI,  16'h0099};
    release_reset();
    run(16);
    n_vec++; if ({halted, imem_addr} !== {1'b1, 8'h07}) begin n_err++; $display("FAIL halt_entry got h%b %h want h1 07", halted, imem_addr); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      run(1);
      if (imem_addr !== 8'h07 || out !== 16'h0042 || halted !== 1'b1) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL halt_hold got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid_exec();
    hold_reset();
    rom[0] = {OP_LDI, 16'hFFFF};
    rom[1] = {OP_ADD, 16'h0002};
    rom[2] = {OP_LDI, 16'h1234};
    release_reset();
    run(5);
    n_vec++; if ({out, carry, imem_addr} !== {16'h0001, 1'b1, 8'h02}) begin n_err++; $display("FAIL pre_reset got %h c%b %h want 0001 c1 02", out, carry, imem_addr); end
    rst_in = 1'b1;
    #1;
    n_vec++; if ({out, carry, halted, error, imem_addr} !== 27'd0) begin n_err++; $display("FAIL async_reset got %h c%b h%b e%b %h want all zero", out, carry, halted, error, imem_addr); end
    @(posedge clk_in);
    #1;
    release_reset();
    run(2);
    n_vec++; if ({out, imem_addr} !== {16'hFFFF, 8'h01}) begin n_err++; $display("FAIL refetch_from_0 got %h %h want ffff 01", out, imem_addr); end
  endtask

  task automatic test_illegal();
    hold_reset();
    rom[0] = {OP_LDI, 16'h0077};
    rom[1] = {8'h55,  16'h0000};
    rom[2] = {OP_LDI, 16'h0011};
    release_reset();
    run(4);
    n_vec++; if ({error, out} !== {1'b1, 16'h0077}) begin n_err++; $display("FAIL illegal got e%b %h want e1 0077", error, out); end
    run(6);
    n_vec++; if ({dut.state_q, out, imem_addr} !== {ST_ERROR, 16'h0077, 8'h01}) begin n_err++; $display("FAIL illegal_frozen got %0d %h %h want %0d 0077 01", dut.state_q, out, imem_addr, ST_ERROR); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_regfile_persist();
    test_carry_logic();
    test_jumps();
    test_call_ret();
    test_stack_faults();
    test_halt();
    test_reset_mid_exec();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/up_core.md
UP_CORE -- requirements
Module: up_core

Interface
REQ-001 SHALL have parameter DATA_W, default 16, accumulator/register/operand width.
REQ-002 SHALL have parameter PC_W, default 8, program address width.
REQ-003 SHALL have parameter REG_NUM, default 16, register-file depth (power of two).
REQ-004 SHALL have parameter STACK_DEPTH, default 4, return-stack entries (power of two).
REQ-005 SHALL have port clk_in  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_in  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port imem_addr  output  PC_W  program memory address.
REQ-008 SHALL have port imem_data  input  8+DATA_W  instruction: [8+DATA_W-1:DATA_W] opcode, [DATA_W-1:0] operand; valid one cycle after imem_addr.
REQ-009 SHALL have port out  output  DATA_W  registered accumulator value.
REQ-010 SHALL have port zero  output  1  accumulator == 0.
REQ-011 SHALL have port carry  output  1  carry/borrow flag from last ADD/SUB/ADDR.
REQ-012 SHALL have port halted  output  1  core stopped by HALT.
REQ-013 SHALL have port error  output  1  sticky stack-overflow/underflow or illegal opcode.

Function
REQ-014 SHALL run FSM states FETCH, EXEC, HALT, ERROR; each instruction takes exactly 2 cycles (FETCH->EXEC->FETCH).
REQ-015 SHALL drive imem_addr = pc in FETCH and sample imem_data in EXEC.
REQ-016 SHALL implement opcodes: NOP 0x00; LDI 0x01 A<=imm; LD 0x02 A<=R[imm]; ST 0x03 R[imm]<=A; ADD 0x04 A<=A+imm; SUB 0x05 A<=A-imm; ADDR 0x06 A<=A+R[imm]; AND 0x07; OR 0x08; XOR 0x09 (A op imm); JMP 0x10; JZ 0x11; JNZ 0x12; CALL 0x13; RET 0x14; HALT 0xFF.
REQ-017 SHALL index the register file with imm[log2(REG_NUM)-1:0], ignoring upper operand bits.
REQ-018 SHALL wrap arithmetic modulo 2^DATA_W; carry = bit DATA_W of the unsigned sum (ADD/ADDR) or borrow (SUB, 1 when A<imm); other opcodes leave carry unchanged.
REQ-019 SHALL evaluate zero combinationally from the updated accumulator register.
REQ-020 SHALL set pc <= imm[PC_W-1:0] on JMP, on JZ when zero=1, on JNZ when zero=0; otherwise pc <= pc+1, wrapping at 2^PC_W.
REQ-021 SHALL on CALL push pc+1 and jump to imm; on RET pop and jump to the popped address (no +1 adjustment).
REQ-022 SHALL on CALL with stack full, or RET with stack empty, set error, leave pc/stack unchanged and enter ERROR.
REQ-023 SHALL treat any unlisted opcode as illegal: set error, enter ERROR.
REQ-024 SHALL on HALT set halted, hold pc at the HALT address, and remain in HALT until reset.
REQ-025 SHALL in HALT and ERROR freeze accumulator, flags, registers, stack, and imem_addr.

Reset
REQ-026 SHALL asynchronously clear on rst_in: pc=0, state=FETCH, accumulator=0, carry=0, halted=0, error=0, stack pointer=0 (empty).
REQ-027 SHALL not clear register-file contents on reset.
REQ-028 SHALL abandon any in-flight instruction on reset asserted mid-EXEC; first fetch after deassertion is address 0.

Structure
REQ-029 SHALL place opcode constants and FSM state encodings in shared package up_pkg.
REQ-030 SHALL implement the return stack as sub-module up_stack (parameters WIDTH=PC_W, DEPTH=STACK_DEPTH; push, pop, full, empty, data_out).
REQ-031 SHALL keep register file, ALU and FSM inline in up_core.

Verification
REQ-032 SHALL verify: LDI 5, ADD 3, ST 2, LDI 0, ADDR 2 -> out=8, zero=0, carry=0, 10 cycles after reset release.
REQ-033 SHALL verify: LDI 0xFFFF, ADD 1 -> out=0, zero=1, carry=1; then SUB 1 -> out=0xFFFF, carry=1.
REQ-034 SHALL verify: LDI 0, JZ 0x20 -> imem_addr=0x20 in next FETCH; LDI 1, JZ 0x20 -> falls through to pc+1.
REQ-035 SHALL verify: CALL 0x40 at addr 3, RET at 0x40 -> next fetch addr 4; five nested CALLs with STACK_DEPTH=4 -> error=1, FSM in ERROR.
REQ-036 SHALL verify: HALT at addr 7 -> halted=1, imem_addr stays 7 for 20 cycles; rst_in pulse mid-EXEC -> all outputs zero, fetch from 0.
REQ-037 SHALL verify: opcode 0x55 -> error=1 and out unchanged.
